// File: rtl/pipe_adder_pkg.sv
// Shared operation encodings and helpers for the pipelined adder.
package pipe_adder_pkg;

  typedef enum logic [1:0] {
    OP_ADDU = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUBU = 2'b10,
    OP_SUB  = 2'b11
  } addOp_e;

  function automatic logic isSub(addOp_e o);
    return (o == OP_SUBU) || (o == OP_SUB);
  endfunction

  function automatic logic isSigned(addOp_e o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One chunk of the pipelined adder: CW-bit add with registered sum and carries.
module pipe_adder_stage #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          ovfRaw
);

  logic [CW:0] full;
  logic        cMsb;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + (CW + 1)'(cin);
    // Carry into the top bit recovered from the sum bit and its operands.
    cMsb = a[CW-1] ^ b[CW-1] ^ full[CW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum    <= '0;
      cout   <= 1'b0;
      ovfRaw <= 1'b0;
    end else if (en) begin
      sum    <= full[CW-1:0];
      cout   <= full[CW];
      ovfRaw <= cMsb ^ full[CW];
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with valid/ready handshake, flush and signed overflow.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [1:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;
  localparam int unsigned NST = STAGES;

  if (WIDTH < 8 || WIDTH > 64 || STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : gBadParams
    $error("pipe_adder: illegal WIDTH/STAGES combination");
  end

  logic             en;
  addOp_e           opIn;
  logic             subIn;
  logic [WIDTH-1:0] bInv;

  // Per-stage state: valid, op, remaining operand chunks (shifted down so the
  // next chunk sits at the bottom) and completed low result chunks.
  logic             vldQ   [STAGES];
  addOp_e           opQ    [STAGES];
  logic [WIDTH-1:0] aQ     [STAGES];
  logic [WIDTH-1:0] bQ     [STAGES];
  logic [WIDTH-1:0] doneQ  [STAGES];
  logic [CW-1:0]    chunkQ [STAGES];
  logic             coutQ  [STAGES];
  logic             ovfQ   [STAGES];
  logic [WIDTH-1:0] view   [STAGES];

  always_comb begin
    en       = !vldQ[STAGES-1] || out_ready;
    in_ready = en;
    opIn     = addOp_e'(op);
    subIn    = isSub(opIn);
    bInv     = subIn ? ~inB : inB;
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    logic [CW-1:0] aIn;
    logic [CW-1:0] bIn;
    logic          cIn;

    if (k == 0) begin : gFirst
      assign aIn = inA[CW-1:0];
      assign bIn = bInv[CW-1:0];
      assign cIn = subIn;
    end else begin : gNext
      assign aIn = aQ[k-1][CW-1:0];
      assign bIn = bQ[k-1][CW-1:0];
      assign cIn = coutQ[k-1];
    end

    pipe_adder_stage #(.CW(CW)) uStage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .a      (aIn),
      .b      (bIn),
      .cin    (cIn),
      .sum    (chunkQ[k]),
      .cout   (coutQ[k]),
      .ovfRaw (ovfQ[k])
    );

    assign view[k] = doneQ[k] | (WIDTH'(chunkQ[k]) << (k * CW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NST; k++) begin
        vldQ[k]  <= 1'b0;
        opQ[k]   <= OP_ADDU;
        aQ[k]    <= '0;
        bQ[k]    <= '0;
        doneQ[k] <= '0;
      end
    end else begin
      // Flush wins over the handshake and clears valids even while stalled.
      if (flush) begin
        for (int unsigned k = 0; k < NST; k++) vldQ[k] <= 1'b0;
      end else if (en) begin
        vldQ[0] <= in_valid;
        for (int unsigned k = 1; k < NST; k++) vldQ[k] <= vldQ[k-1];
      end
      if (en) begin
        opQ[0]   <= opIn;
        aQ[0]    <= inA >> CW;
        bQ[0]    <= bInv >> CW;
        doneQ[0] <= '0;
        for (int unsigned k = 1; k < NST; k++) begin
          opQ[k]   <= opQ[k-1];
          aQ[k]    <= aQ[k-1] >> CW;
          bQ[k]    <= bQ[k-1] >> CW;
          doneQ[k] <= view[k-1];
        end
      end
    end
  end

  always_comb begin
    out_valid = vldQ[STAGES-1];
    out       = view[STAGES-1];
    carry     = coutQ[STAGES-1];
    ovf       = isSigned(opQ[STAGES-1]) && ovfQ[STAGES-1];
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench: three pipe_adder depths (2, 1, 4) share one stimulus stream.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    int unsigned acc;
    bit          lat;
  } expT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic [31:0] inA;
  logic [31:0] inB;
  logic [1:0]  op;
  logic        flush;
  logic        outReady;
  bit          latChk;

  logic        inReadyW  [3];
  logic        outValidW [3];
  logic [31:0] outW      [3];
  logic        carryW    [3];
  logic        ovfW      [3];
  int          pend      [3];

  int          nTotal = 0;
  int          nBad   = 0;
  int unsigned cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input longint unsigned act,
                       input longint unsigned want);
    nTotal++;
    if (!ok) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic expT model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    expT    e;
    longint sa, sb, sr;
    sa = $signed(a);
    sb = $signed(b);
    e.acc = 0;
    e.lat = 1'b0;
    if (o == OP_ADDU || o == OP_ADD) begin
      e.res = a + b;
      e.c   = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
      sr    = sa + sb;
    end else begin
      e.res = a - b;
      e.c   = (a >= b);
      sr    = sa - sb;
    end
    e.v = (o == OP_ADD || o == OP_SUB) && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int ST = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    pipe_adder #(.WIDTH(32), .STAGES(ST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReadyW[g]),
      .inA       (inA),
      .inB       (inB),
      .op        (op),
      .flush     (flush),
      .out_valid (outValidW[g]),
      .out_ready (outReady),
      .out       (outW[g]),
      .carry     (carryW[g]),
      .ovf       (ovfW[g])
    );

    expT q[$];
    bit  seen = 1'b0;

    always @(negedge clk) begin : mon
      expT e;
      if (!rst_n) begin
        q.delete();
        seen = 1'b0;
      end else begin
        check(inReadyW[g] == (!outValidW[g] || outReady), $sformatf("s%0d in_ready", ST),
              inReadyW[g], !outValidW[g] || outReady);
        if (outValidW[g]) begin
          if (q.size() == 0) begin
            check(1'b0, $sformatf("s%0d unexpected result", ST), outW[g], 0);
          end else begin
            e = q[0];
            check(outW[g] == e.res, $sformatf("s%0d out", ST), outW[g], e.res);
            check(carryW[g] == e.c, $sformatf("s%0d carry", ST), carryW[g], e.c);
            check(ovfW[g] == e.v, $sformatf("s%0d ovf", ST), ovfW[g], e.v);
            if (!seen && e.lat)
              check(cyc == e.acc + ST, $sformatf("s%0d latency", ST), cyc - e.acc, ST);
            seen = 1'b1;
            if (outReady) begin
              void'(q.pop_front());
              seen = 1'b0;
            end
          end
        end
        if (flush) begin
          q.delete();
          seen = 1'b0;
        end else if (inValid && inReadyW[g]) begin
          e     = model(inA, inB, op);
          e.acc = cyc;
          e.lat = latChk;
          q.push_back(e);
        end
      end
      pend[g] = q.size();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    bit ok;
    ok = 1'b0;
    inA = a; inB = b; op = o; inValid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = inReadyW[0];
      @(posedge clk);
      #1;
    end
    if (!ok) check(1'b0, "send accept timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      #1;
      done = (pend[0] == 0) && (pend[1] == 0) && (pend[2] == 0);
    end
    if (!done) check(1'b0, "drain timeout", pend[0] + pend[1] + pend[2], 0);
    tick(1);
  endtask

  task automatic checkIdle(input string tag);
    for (int i = 0; i < 3; i++) begin
      check(outValidW[i] == 1'b0, $sformatf("%s dut%0d out_valid", tag, i), outValidW[i], 0);
      check(outW[i] == 32'd0, $sformatf("%s dut%0d out", tag, i), outW[i], 0);
      check(carryW[i] == 1'b0, $sformatf("%s dut%0d carry", tag, i), carryW[i], 0);
      check(ovfW[i] == 1'b0, $sformatf("%s dut%0d ovf", tag, i), ovfW[i], 0);
      check(inReadyW[i] == 1'b1, $sformatf("%s dut%0d in_ready", tag, i), inReadyW[i], 1);
    end
  endtask

  function automatic logic [31:0] rndOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; inValid = 1'b0; inA = '0; inB = '0; op = '0;
    flush = 1'b0; outReady = 1'b1; latChk = 1'b0;
    tick(2);
    checkIdle("reset");
    rst_n = 1'b1;
    tick(1);

    // Arithmetic corners with exact latency
    latChk = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADDU);
    send(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
    send(32'h8000_0000, 32'h0000_0001, OP_SUB);
    send(32'h0000_0005, 32'h0000_0007, OP_SUBU);
    send(32'h8000_0000, 32'h8000_0000, OP_ADD);
    send(32'h0000_0000, 32'h0000_0000, OP_SUBU);
    inValid = 1'b0;
    drain();

    // Backpressure: hold the first result for three cycles
    latChk = 1'b0;
    fork
      begin
        send(32'd1, 32'd1, OP_ADDU);
        send(32'd2, 32'd2, OP_ADDU);
        send(32'd3, 32'd3, OP_ADDU);
        send(32'd4, 32'd4, OP_ADDU);
        inValid = 1'b0;
      end
      begin
        bit got;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
          @(posedge clk);
          #1;
          got = outValidW[0];
        end
        if (!got) check(1'b0, "first result timeout", 0, 1);
        outReady = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check(inReadyW[0] == 1'b0, "stall in_ready", inReadyW[0], 0);
          check(outW[0] == 32'd2, "stall out held", outW[0], 2);
          @(posedge clk);
          #1;
        end
        outReady = 1'b1;
      end
    join
    drain();

    // Flush with two beats in flight, then a clean beat
    outReady = 1'b0;
    send(32'd1, 32'd2, OP_ADDU);
    send(32'd3, 32'd4, OP_ADDU);
    inValid = 1'b0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    for (int i = 0; i < 3; i++)
      check(outValidW[i] == 1'b0, $sformatf("flush dut%0d out_valid", i), outValidW[i], 0);
    outReady = 1'b1;
    latChk = 1'b1;
    send(32'd10, 32'd20, OP_ADDU);
    inValid = 1'b0;
    drain();

    // Asynchronous reset in the middle of a stream
    latChk = 1'b0;
    send(32'd100, 32'd1, OP_ADD);
    send(32'hFFFF_FFF0, 32'd1, OP_SUB);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("async reset");
    inValid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    latChk = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADDU);
    inValid = 1'b0;
    drain();

    // Random stream, consumer always ready: latency checked on every beat
    for (int i = 0; i < 200; i++) begin
      inValid = ($urandom_range(0, 3) != 0);
      inA = rndOperand();
      inB = rndOperand();
      op = 2'($urandom_range(0, 3));
      tick(1);
    end
    inValid = 1'b0;
    drain();

    // Random stream with backpressure and occasional flushes
    latChk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      inValid = ($urandom_range(0, 3) != 0);
      inA = rndOperand();
      inB = rndOperand();
      op = 2'($urandom_range(0, 3));
      outReady = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      tick(1);
    end
    inValid = 1'b0;
    flush = 1'b0;
    outReady = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
